// File: rtl/lpm_result_queue_if.sv
// Handshake and status bundle between the LPM wrapper indication port, the result queue
// and the host portal.
interface lpm_result_queue_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             in__ENA;
  logic [WIDTH-1:0] in_data;
  logic             in__RDY;
  logic             out__ENA;
  logic [WIDTH-1:0] out_data;
  logic             out__RDY;
  logic             flush__ENA;
  logic             flush__RDY;
  logic [CW-1:0]    count;
  logic             hiwater;
  logic [31:0]      total;
  logic             proto_err;

  modport master (
    output in__ENA, in_data, out__ENA, flush__ENA,
    input  in__RDY, out_data, out__RDY, flush__RDY, count, hiwater, total, proto_err
  );

  modport slave (
    input  in__ENA, in_data, out__ENA, flush__ENA,
    output in__RDY, out_data, out__RDY, flush__RDY, count, hiwater, total, proto_err
  );
endinterface

// File: rtl/lpm_result_queue.sv
// Result FIFO between the LPM wrapper and the host portal, with occupancy, high-water,
// running result count and sticky protocol-error status.
module lpm_result_queue #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned HIWATER = 6
) (
  input  logic                 CLK,
  input  logic                 nRST,
  lpm_result_queue_if.slave    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [31:0]      r_total;
  logic             r_proto_err;
  logic             r_hiwater;

  logic             w_in_rdy;
  logic             w_out_rdy;
  logic             w_enq;
  logic             w_deq;
  logic             w_err;
  logic [CW-1:0]    w_count_d;

  // Ready flags come only from registered occupancy, so ENA never loops back into RDY.
  assign w_in_rdy  = (r_count != CW'(DEPTH));
  assign w_out_rdy = (r_count != '0);
  assign w_enq     = bus.in__ENA & w_in_rdy;
  assign w_deq     = bus.out__ENA & w_out_rdy;
  assign w_err     = (bus.in__ENA & ~w_in_rdy) | (bus.out__ENA & ~w_out_rdy);

  always_comb begin
    w_count_d = r_count;
    if (bus.flush__ENA) begin
      w_count_d = '0;
    end else begin
      w_count_d = r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_total     <= '0;
      r_proto_err <= 1'b0;
      r_hiwater   <= 1'b0;
    end else begin
      r_count   <= w_count_d;
      r_hiwater <= (w_count_d >= CW'(HIWATER));
      if (w_err) begin
        r_proto_err <= 1'b1;
      end
      if (bus.flush__ENA) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_enq) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
          r_total  <= r_total + 32'd1;
        end
        if (w_deq) begin
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
      end
    end
  end

  // Storage is intentionally left out of reset.
  always_ff @(posedge CLK) begin
    if (w_enq && !bus.flush__ENA) begin
      r_mem[r_wr_ptr] <= bus.in_data;
    end
  end

  assign bus.in__RDY    = w_in_rdy;
  assign bus.out__RDY   = w_out_rdy;
  assign bus.out_data   = w_out_rdy ? r_mem[r_rd_ptr] : '0;
  assign bus.flush__RDY = 1'b1;
  assign bus.count      = r_count;
  assign bus.hiwater    = r_hiwater;
  assign bus.total      = r_total;
  assign bus.proto_err  = r_proto_err;
endmodule

// File: tb/tb_lpm_result_queue.sv
// Directed bench for lpm_result_queue: ordering, full/empty corners, wrap, flush and reset.
module tb_lpm_result_queue;
  logic CLK;
  logic nRST;
  int   n_cmp;
  int   n_err;
  logic [31:0] exp_q[$];

  lpm_result_queue_if #(.WIDTH(32), .DEPTH(8)) bus ();

  lpm_result_queue #(.WIDTH(32), .DEPTH(8), .HIWATER(6)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".in_rdy"},  32'(bus.in__RDY),   32'd1);
    check({tag, ".out_rdy"}, 32'(bus.out__RDY),  32'd0);
    check({tag, ".count"},   32'(bus.count),     32'd0);
    check({tag, ".total"},   bus.total,          32'd0);
    check({tag, ".perr"},    32'(bus.proto_err), 32'd0);
    check({tag, ".hiwater"}, 32'(bus.hiwater),   32'd0);
    check({tag, ".data"},    bus.out_data,       32'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    bus.in__ENA = 1'b0; bus.out__ENA = 1'b0; bus.flush__ENA = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;
    #4;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    do_reset();
    check_reset_state("rst");
    check("flush_rdy", 32'(bus.flush__RDY), 32'd1);

    // In-order enqueue then drain
    bus.in__ENA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'hA1 + 32'(i);
      cyc();
    end
    bus.in__ENA = 1'b0;
    check("s2.count3", 32'(bus.count), 32'd3);
    bus.out__ENA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("s2.head%0d", i), bus.out_data, 32'hA1 + 32'(i));
      cyc();
    end
    bus.out__ENA = 1'b0;
    check("s2.count0", 32'(bus.count), 32'd0);
    check("s2.total", bus.total, 32'd3);
    check("s2.out_rdy", 32'(bus.out__RDY), 32'd0);

    // Fill to full, watch hiwater and in__RDY
    bus.in__ENA = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 32'hB0 + 32'(i);
      cyc();
      check($sformatf("s3.count%0d", i + 1), 32'(bus.count), 32'(i + 1));
      check($sformatf("s3.hiw%0d", i + 1), 32'(bus.hiwater), (i + 1 >= 6) ? 32'd1 : 32'd0);
      check($sformatf("s3.inrdy%0d", i + 1), 32'(bus.in__RDY), (i + 1 != 8) ? 32'd1 : 32'd0);
    end
    bus.in_data = 32'hFF;
    cyc();
    bus.in__ENA = 1'b0;
    check("s3.ovf_count", 32'(bus.count), 32'd8);
    check("s3.ovf_perr", 32'(bus.proto_err), 32'd1);
    check("s3.ovf_total", bus.total, 32'd11);
    check("s3.head", bus.out_data, 32'hB0);

    // Full: enq+deq together, only deq fires
    bus.in__ENA = 1'b1; bus.out__ENA = 1'b1; bus.in_data = 32'hC0;
    cyc();
    bus.in__ENA = 1'b0;
    check("s4.full_count", 32'(bus.count), 32'd7);
    check("s4.full_inrdy", 32'(bus.in__RDY), 32'd1);
    check("s4.full_head", bus.out_data, 32'hB1);
    check("s4.full_total", bus.total, 32'd11);
    repeat (3) cyc();
    check("s4.mid_count", 32'(bus.count), 32'd4);
    check("s4.mid_head0", bus.out_data, 32'hB4);
    bus.in__ENA = 1'b1; bus.in_data = 32'hC1;
    cyc();
    bus.in__ENA = 1'b0; bus.out__ENA = 1'b0;
    check("s4.mid_count2", 32'(bus.count), 32'd4);
    check("s4.mid_head1", bus.out_data, 32'hB5);
    check("s4.mid_total", bus.total, 32'd12);

    // Wrap: 3 queued, then 20 enq/deq pairs
    do_reset();
    exp_q.delete();
    bus.in__ENA = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 32'hD0 + 32'(i);
      exp_q.push_back(bus.in_data);
      cyc();
    end
    bus.out__ENA = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 32'h100 + 32'(i);
      check($sformatf("s5.head%0d", i), bus.out_data, exp_q[0]);
      exp_q.push_back(bus.in_data);
      void'(exp_q.pop_front());
      cyc();
    end
    bus.out__ENA = 1'b0; bus.in__ENA = 1'b0;
    check("s5.count", 32'(bus.count), 32'd3);
    check("s5.total", bus.total, 32'd23);
    check("s5.head_end", bus.out_data, 32'h111);
    check("s5.perr", 32'(bus.proto_err), 32'd0);

    // Flush at count=5 with in__ENA high
    bus.in__ENA = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.in_data = 32'hE0 + 32'(i);
      cyc();
    end
    check("s6.count5", 32'(bus.count), 32'd5);
    bus.flush__ENA = 1'b1; bus.in_data = 32'hEE;
    cyc();
    bus.flush__ENA = 1'b0; bus.in__ENA = 1'b0;
    check("s6.fl_count", 32'(bus.count), 32'd0);
    check("s6.fl_outrdy", 32'(bus.out__RDY), 32'd0);
    check("s6.fl_total", bus.total, 32'd25);
    check("s6.fl_data", bus.out_data, 32'd0);
    check("s6.fl_perr", 32'(bus.proto_err), 32'd0);
    bus.in__ENA = 1'b1; bus.in_data = 32'hF0;
    cyc();
    check("s6.post_head", bus.out_data, 32'hF0);
    check("s6.post_total", bus.total, 32'd26);

    // Async reset mid-burst
    bus.in_data = 32'hF1;
    cyc();
    bus.in_data = 32'hF2;
    #2;
    nRST = 1'b0;
    #1;
    check_reset_state("s6.arst");
    bus.in__ENA = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    cyc();
    check_reset_state("s6.arst_rel");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
